// File: rtl/alu_control_seq.sv
// Registered ALU control stage between ID and EX: decodes one instruction per
// handshake, sequences multi-cycle MUL, owns NZCV and an illegal-decode counter.
module alu_control_seq #(
  parameter int MUL_CYCLES    = 4,
  parameter int ENABLE_MUL    = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               aluop,
  input  logic [10:0]              opcode,
  input  logic                     flush,
  input  logic [3:0]               alu_nzcv,
  output logic                     ex_valid,
  output logic                     ex_done,
  output logic [3:0]               ex_control,
  output logic                     ex_setflags,
  output logic                     ex_illegal,
  output logic [3:0]               nzcv,
  output logic                     stall,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, ONE, MULTI} state_t;

  state_t     state;
  logic [3:0] mul_cnt;
  logic [3:0] dec_control;
  logic       dec_setflags;
  logic       dec_illegal;
  logic       dec_mul;
  logic       accept;

  always_comb begin
    dec_control  = 4'b1111;
    dec_setflags = 1'b0;
    dec_illegal  = 1'b1;
    dec_mul      = 1'b0;
    case (aluop)
      2'b00: begin {dec_control, dec_setflags} = 5'b0010_0; dec_illegal = 1'b0; end
      2'b01: begin {dec_control, dec_setflags} = 5'b0111_1; dec_illegal = 1'b0; end
      2'b10: begin
        dec_illegal = 1'b0;
        case (opcode)
          11'b10001011000: {dec_control, dec_setflags} = 5'b0010_0; // ADD
          11'b10101011000: {dec_control, dec_setflags} = 5'b0010_1; // ADDS
          11'b11001011000: {dec_control, dec_setflags} = 5'b0110_0; // SUB
          11'b11101011000: {dec_control, dec_setflags} = 5'b0110_1; // SUBS
          11'b10001010000: {dec_control, dec_setflags} = 5'b0000_0; // AND
          11'b11101010000: {dec_control, dec_setflags} = 5'b0000_1; // ANDS
          11'b10101010000: {dec_control, dec_setflags} = 5'b0001_0; // ORR
          11'b11001010000: {dec_control, dec_setflags} = 5'b1000_0; // EOR
          11'b11010011010: {dec_control, dec_setflags} = 5'b1010_0; // LSR
          11'b11010011011: {dec_control, dec_setflags} = 5'b1011_0; // LSL
          11'b11111000010: {dec_control, dec_setflags} = 5'b0010_0; // LDUR
          11'b11111000000: {dec_control, dec_setflags} = 5'b0010_0; // STUR
          11'b10011011000: begin
            if (ENABLE_MUL != 0) begin
              {dec_control, dec_setflags} = 5'b0011_0;
              dec_mul = 1'b1;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: begin
            // Immediate forms ignore the low opcode bit.
            case (opcode[10:1])
              10'b1001000100: {dec_control, dec_setflags} = 5'b0010_0; // ADDI
              10'b1001001000: {dec_control, dec_setflags} = 5'b0000_0; // ANDI
              10'b1011001000: {dec_control, dec_setflags} = 5'b0001_0; // ORRI
              10'b1101000100: {dec_control, dec_setflags} = 5'b0110_0; // SUBI
              10'b1101001000: {dec_control, dec_setflags} = 5'b1000_0; // EORI
              10'b1011000100: {dec_control, dec_setflags} = 5'b0010_1; // ADDIS
              10'b1111000100: {dec_control, dec_setflags} = 5'b0110_1; // SUBIS
              10'b1111001000: {dec_control, dec_setflags} = 5'b0000_1; // ANDIS
              default:        dec_illegal = 1'b1;
            endcase
          end
        endcase
      end
      default: ;
    endcase
  end

  assign ex_valid = (state != IDLE);
  assign ex_done  = (state == ONE) | ((state == MULTI) & (mul_cnt == 4'd0));
  assign stall    = ex_valid & ~ex_done;
  assign in_ready = ~flush & ((state == IDLE) | ex_done);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mul_cnt     <= 4'd0;
      ex_control  <= 4'b1111;
      ex_setflags <= 1'b0;
      ex_illegal  <= 1'b0;
      nzcv        <= 4'b0000;
      err_count   <= '0;
    end else if (flush) begin
      state       <= IDLE;
      mul_cnt     <= 4'd0;
      ex_control  <= 4'b1111;
      ex_setflags <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      if (ex_done & ex_setflags & ~ex_illegal)
        nzcv <= alu_nzcv;
      if (accept) begin
        ex_control  <= dec_control;
        ex_setflags <= dec_setflags;
        ex_illegal  <= dec_illegal;
        state       <= dec_mul ? MULTI : ONE;
        mul_cnt     <= 4'(MUL_CYCLES - 1);
        if (dec_illegal && (err_count != '1))
          err_count <= err_count + ERR_CNT_WIDTH'(1);
      end else if (ex_done) begin
        state <= IDLE;
      end else if (state == MULTI) begin
        mul_cnt <= mul_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode, MUL sequencing, flags, illegal
// counting, flush and asynchronous reset.
module tb_alu_control_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluop;
  logic [10:0] opcode;
  logic        flush;
  logic [3:0]  alu_nzcv;
  logic        ex_valid;
  logic        ex_done;
  logic [3:0]  ex_control;
  logic        ex_setflags;
  logic        ex_illegal;
  logic [3:0]  nzcv;
  logic        stall;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_control_seq #(.MUL_CYCLES(4), .ENABLE_MUL(1), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .opcode(opcode), .flush(flush), .alu_nzcv(alu_nzcv),
    .ex_valid(ex_valid), .ex_done(ex_done), .ex_control(ex_control),
    .ex_setflags(ex_setflags), .ex_illegal(ex_illegal), .nzcv(nzcv),
    .stall(stall), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc);
    in_valid = v;
    aluop    = op;
    opcode   = opc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alu_nzcv = 4'b0000;
    drive(1'b0, 2'b00, 11'd0);
    #3;
    check("rst_control", 16'(ex_control), 16'hf);
    check("rst_valid", 16'(ex_valid), 16'h0);
    check("rst_nzcv", 16'(nzcv), 16'h0);
    check("rst_err", 16'(err_count), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("idle_ready", 16'(in_ready), 16'h1);
    $display("txn reset done");

    // ADDS
    drive(1'b1, 2'b10, 11'b10101011000); alu_nzcv = 4'b0110;
    step();
    check("adds_control", 16'(ex_control), 16'h2);
    check("adds_setflags", 16'(ex_setflags), 16'h1);
    check("adds_done", 16'(ex_done), 16'h1);
    drive(1'b0, 2'b00, 11'd0);
    step();
    check("adds_nzcv", 16'(nzcv), 16'h6);
    check("adds_idle", 16'(ex_valid), 16'h0);
    $display("txn ADDS nzcv=%b", nzcv);

    // MUL with ADD queued behind it
    drive(1'b1, 2'b10, 11'b10011011000); alu_nzcv = 4'b1111;
    step();
    drive(1'b1, 2'b10, 11'b10001011000);
    #1;
    check("mul_c1_stall", 16'(stall), 16'h1);
    check("mul_c1_ready", 16'(in_ready), 16'h0);
    check("mul_c1_control", 16'(ex_control), 16'h3);
    step();
    check("mul_c2_stall", 16'(stall), 16'h1);
    check("mul_c2_ready", 16'(in_ready), 16'h0);
    step();
    check("mul_c3_stall", 16'(stall), 16'h1);
    step();
    check("mul_c4_stall", 16'(stall), 16'h0);
    check("mul_c4_done", 16'(ex_done), 16'h1);
    check("mul_c4_ready", 16'(in_ready), 16'h1);
    check("mul_c4_valid", 16'(ex_valid), 16'h1);
    step();
    check("add_c5_control", 16'(ex_control), 16'h2);
    check("add_c5_valid", 16'(ex_valid), 16'h1);
    check("add_c5_done", 16'(ex_done), 16'h1);
    drive(1'b0, 2'b00, 11'd0);
    step();
    check("idle_hold_control", 16'(ex_control), 16'h2);
    check("mul_add_nzcv", 16'(nzcv), 16'h6);
    $display("txn MUL+ADD nzcv=%b", nzcv);

    // SUBIS then SUB
    drive(1'b1, 2'b10, 11'b11110001000); alu_nzcv = 4'b1001;
    step();
    check("subis_control", 16'(ex_control), 16'h6);
    check("subis_setflags", 16'(ex_setflags), 16'h1);
    drive(1'b1, 2'b10, 11'b11001011000);
    step();
    check("subis_nzcv", 16'(nzcv), 16'h9);
    check("sub_setflags", 16'(ex_setflags), 16'h0);
    drive(1'b0, 2'b00, 11'd0); alu_nzcv = 4'b0011;
    step();
    check("sub_nzcv", 16'(nzcv), 16'h9);
    $display("txn SUBIS+SUB nzcv=%b", nzcv);

    // Illegal decodes, 300 total, counter saturates
    drive(1'b1, 2'b11, 11'd0); alu_nzcv = 4'b0000;
    step();
    check("ill_control", 16'(ex_control), 16'hf);
    check("ill_flag", 16'(ex_illegal), 16'h1);
    check("ill_err1", 16'(err_count), 16'h1);
    drive(1'b1, 2'b10, 11'd0);
    for (int i = 2; i <= 300; i++) begin
      step();
      if (i == 254) check("ill_err254", 16'(err_count), 16'd254);
    end
    check("ill_err_sat", 16'(err_count), 16'd255);
    check("ill_nzcv", 16'(nzcv), 16'h9);
    drive(1'b0, 2'b00, 11'd0);
    step();
    $display("txn illegal x300 err_count=%0d", err_count);

    // Flush in MUL cycle 2 with ADDS pending
    drive(1'b1, 2'b10, 11'b10011011000); alu_nzcv = 4'b1111;
    step();
    drive(1'b1, 2'b10, 11'b10101011000);
    step();
    flush = 1'b1;
    #1;
    check("flush_ready", 16'(in_ready), 16'h0);
    step();
    flush = 1'b0;
    #1;
    check("flush_valid", 16'(ex_valid), 16'h0);
    check("flush_control", 16'(ex_control), 16'hf);
    check("flush_setflags", 16'(ex_setflags), 16'h0);
    check("flush_nzcv", 16'(nzcv), 16'h9);
    check("flush_ready_after", 16'(in_ready), 16'h1);
    alu_nzcv = 4'b0100;
    step();
    check("post_flush_control", 16'(ex_control), 16'h2);
    check("post_flush_done", 16'(ex_done), 16'h1);
    drive(1'b0, 2'b00, 11'd0);
    step();
    check("post_flush_nzcv", 16'(nzcv), 16'h4);
    $display("txn flush nzcv=%b", nzcv);

    // Asynchronous reset mid-MUL
    drive(1'b1, 2'b10, 11'b10011011000);
    step();
    drive(1'b0, 2'b00, 11'd0);
    step();
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 16'(ex_valid), 16'h0);
    check("arst_stall", 16'(stall), 16'h0);
    check("arst_control", 16'(ex_control), 16'hf);
    check("arst_nzcv", 16'(nzcv), 16'h0);
    check("arst_err", 16'(err_count), 16'h0);
    rst = 1'b0;
    step();
    check("arst_idle", 16'(ex_valid), 16'h0);
    $display("txn async reset nzcv=%b", nzcv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised sequential successor of the combinational ALU control decoder.
- Sits between ID and EX. Accepts one decoded instruction per handshake and holds the registered ALU control and setflags for EX.
- Sequences multi-cycle MUL operations and stalls ID while they run.
- Owns the architectural NZCV flag register and a saturating count of illegal decodes.

Parameters:
- MUL_CYCLES, 4, EX occupancy in cycles for MUL; legal range 2..16.
- ENABLE_MUL, 1, when 0 the MUL opcode decodes as illegal.
- ERR_CNT_WIDTH, 8, width of the illegal-decode counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ID presents an instruction.
- in_ready  output  1  block accepts the instruction this cycle.
- aluop  input  2  main-control ALU op class.
- opcode  input  11  instruction bits [31:21].
- flush  input  1  synchronous kill of the EX-held operation.
- alu_nzcv  input  4  flags from the ALU; sampled only on the completion cycle.
- ex_valid  output  1  EX holds an operation.
- ex_done  output  1  last EX cycle of the held operation.
- ex_control  output  4  registered ALU control.
- ex_setflags  output  1  held operation writes NZCV.
- ex_illegal  output  1  held operation failed decode.
- nzcv  output  4  architectural flags {N,Z,C,V}.
- stall  output  1  equals ex_valid & ~ex_done.
- err_count  output  ERR_CNT_WIDTH  saturating illegal-decode count.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, ex_control=4'b1111; ex_setflags, ex_illegal, nzcv, err_count and the MUL counter all 0.
  - Effect is immediate, not waiting for a clock edge.
- Decode (combinational, registered on accept), {control, setflags}:
  - aluop 00: 0010, 0.
  - aluop 01: 0111, 1.
  - aluop 11: illegal.
  - aluop 10, full 11-bit opcode: ADD 10001011000 →0010,0. ADDS 10101011000 →0010,1. SUB 11001011000 →0110,0. SUBS 11101011000 →0110,1. AND 10001010000 →0000,0. ANDS 11101010000 →0000,1. ORR 10101010000 →0001,0. EOR 11001010000 →1000,0. LSR 11010011010 →1010,0. LSL 11010011011 →1011,0. LDUR 11111000010 →0010,0. STUR 11111000000 →0010,0. MUL 10011011000 →0011,0 (multi-cycle).
  - aluop 10, opcode[10:1]: ADDI 1001000100 →0010,0. ANDI 1001001000 →0000,0. ORRI 1011001000 →0001,0. SUBI 1101000100 →0110,0. EORI 1101001000 →1000,0. ADDIS 1011000100 →0010,1. SUBIS 1111000100 →0110,1. ANDIS 1111001000 →0000,1.
  - Illegal (no match): control 1111, setflags 0, ex_illegal 1. It still occupies EX for 1 cycle.
- in_ready = ~flush & (state==IDLE | ex_done). Accept = in_valid & in_ready.
- FSM states:
  - IDLE: ex_valid=0. On accept go to ONE, or to MULTI for MUL.
  - ONE: ex_valid=1, ex_done=1. On accept go to ONE or MULTI; otherwise go to IDLE.
  - MULTI: ex_valid=1. The counter loads MUL_CYCLES-1 on entry and decrements each cycle. ex_done=1 when the counter is 0; next-state rules on that cycle are the same as ONE.
- Back-to-back: a new operation is accepted in the done cycle of the previous one. There are no bubbles.
- Flags:
  - nzcv <= alu_nzcv on the rising edge where ex_done & ex_setflags & ~ex_illegal & ~flush.
  - nzcv holds otherwise. nzcv is never written mid-MUL.
- Flush:
  - At the next edge: state=IDLE, ex_control=1111, ex_setflags=0, ex_illegal=0, no flag write.
  - Flush wins over a simultaneous accept; in_ready is 0 while flush is high.
  - Flush during MULTI abandons the counter.
- err_count increments on each accepted illegal decode and saturates at all-ones. It clears only on rst.
- Output fields hold their values when in the IDLE state.
- ENABLE_MUL=0: MUL is illegal and the MULTI state is unreachable.

Test Plan:
- Reset then ADDS (aluop 10, opcode 10101011000), alu_nzcv=4'b0110 → next cycle ex_control=0010, ex_setflags=1, ex_done=1; nzcv=0110 after that edge.
- MUL (10011011000), MUL_CYCLES=4, in_valid held with ADD behind it → ex_valid=1 for 4 cycles, stall=1 for cycles 1-3, in_ready=1 only in cycle 4, ADD enters EX in cycle 5 with no bubble.
- SUBIS (opcode[10:1]=1111000100) followed by SUB → nzcv updates once, from the SUBIS done cycle only; SUB leaves nzcv unchanged.
- aluop 11, then aluop 10 with opcode 00000000000, 300 times with ERR_CNT_WIDTH=8 → ex_control=1111, ex_illegal=1, nzcv unchanged, err_count saturates at 255.
- Flush asserted in MUL cycle 2 with in_valid=1 → in_ready=0 that cycle; IDLE next cycle, ex_control=1111, nzcv unchanged; the pending instruction is accepted the cycle after.
- rst pulsed asynchronously mid-MUL (no clock edge) → outputs immediately at reset values, nzcv=0000, state IDLE.
